// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W        = 64;
  localparam int INSTR_W     = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DRAIN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface fetch_ctrl_if #(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: clear beats hold beats load; otherwise a bubble.
module ifid_reg #(
  parameter int PC_W    = fetch_pkg::PC_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               hold_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;

  // Data fields keep their old value on clear so only valid toggles.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (hold_i) begin
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch stage: owns the PC, keeps one imem request in flight, feeds IF/ID,
// drops wrong-path responses after a redirect and buffers one across a stall.
module fetch_ctrl #(
  parameter int              PC_W         = fetch_pkg::PC_W,
  parameter int              INSTR_W      = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_M,
  input  logic [PC_W-1:0]    PCBranch_M,
  input  logic               stall_D,
  input  logic               flush_D,
  fetch_ctrl_if.master       imem,
  output logic [INSTR_W-1:0] instr_D,
  output logic [PC_W-1:0]    pc_D,
  output logic               valid_D
);

  import fetch_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

  logic               accepted;
  logic               deliver;
  logic [INSTR_W-1:0] deliver_instr;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    pc_inc;
  logic               unused_target_lsbs;

  assign target             = {PCBranch_M[PC_W-1:2], 2'b00};
  assign pc_inc             = pc_q + PC_W'(INSTR_BYTES);
  assign accepted           = imem.imem_req & imem.imem_ready;
  assign unused_target_lsbs = ^PCBranch_M[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_VECTOR;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // PC stays on the fetched instruction until it is handed to decode, so the
  // IF/ID pc is taken from pc_q and the hold buffer only needs the data.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    unique case (state_q)
      FETCH: begin
        if (PCSrc_M) pc_d = target;
        if (accepted) state_d = PCSrc_M ? DRAIN : WAIT;
      end
      WAIT: begin
        if (PCSrc_M) begin
          pc_d    = target;
          state_d = imem.imem_valid ? FETCH : DRAIN;
        end else if (imem.imem_valid) begin
          if (stall_D) begin
            hold_instr_d = imem.imem_rdata;
            state_d      = HOLD;
          end else begin
            pc_d    = pc_inc;
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (PCSrc_M) pc_d = target;
        if (imem.imem_valid) state_d = FETCH;
      end
      HOLD: begin
        if (PCSrc_M) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_D) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state_q == FETCH);
    imem.imem_addr = pc_q;
    deliver        = 1'b0;
    deliver_instr  = imem.imem_rdata;
    unique case (state_q)
      WAIT: begin
        deliver       = imem.imem_valid & ~PCSrc_M & ~stall_D;
        deliver_instr = imem.imem_rdata;
      end
      HOLD: begin
        deliver       = ~PCSrc_M & ~stall_D;
        deliver_instr = hold_instr_q;
      end
      default: ;
    endcase
  end

  ifid_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (PCSrc_M | flush_D),
    .hold_i  (stall_D),
    .load_i  (deliver),
    .instr_i (deliver_instr),
    .pc_i    (pc_q),
    .instr_o (instr_D),
    .pc_o    (pc_D),
    .valid_o (valid_D)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with a small variable-latency imem model.
module tb_fetch_ctrl;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               PCSrc_M;
  logic [PC_W-1:0]    PCBranch_M;
  logic               stall_D;
  logic               flush_D;
  logic [INSTR_W-1:0] instr_D;
  logic [PC_W-1:0]    pc_D;
  logic               valid_D;

  fetch_ctrl_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

  fetch_ctrl #(
    .PC_W         (PC_W),
    .INSTR_W      (INSTR_W),
    .RESET_VECTOR (64'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc_M    (PCSrc_M),
    .PCBranch_M (PCBranch_M),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .imem       (imem),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t          exp_ifid[$];
  logic [PC_W-1:0] exp_req[$];
  string           dname_q[$];
  logic [63:0]     dgot_q[$];
  logic [63:0]     dexp_q[$];

  int checks = 0;
  int errors = 0;

  // Memory model state
  logic            pend = 1'b0;
  logic [PC_W-1:0] pend_addr;
  int unsigned     pend_cnt;
  int unsigned     lat = 1;

  function automatic logic [INSTR_W-1:0] tag(input logic [PC_W-1:0] a);
    tag = {8'hC3, a[23:0]};
  endfunction

  task automatic push_fetch(input logic [PC_W-1:0] a);
    entry_t e;
    e.pc    = a;
    e.instr = tag(a);
    exp_ifid.push_back(e);
  endtask

  task automatic direct(input string name, input logic [63:0] got, input logic [63:0] exp);
    dname_q.push_back(name);
    dgot_q.push_back(got);
    dexp_q.push_back(exp);
  endtask

  // One clock cycle: response from the model, then inputs, then acceptance.
  task automatic step(input logic pcsrc, input logic [PC_W-1:0] tgt,
                      input logic stall, input logic flush, input logic rdy);
    @(posedge clk);
    #1;
    if (pend && pend_cnt == 0) begin
      imem.imem_valid = 1'b1;
      imem.imem_rdata = tag(pend_addr);
      pend            = 1'b0;
    end else begin
      imem.imem_valid = 1'b0;
      imem.imem_rdata = '0;
      if (pend) pend_cnt = pend_cnt - 1;
    end
    PCSrc_M         = pcsrc;
    PCBranch_M      = tgt;
    stall_D         = stall;
    flush_D         = flush;
    imem.imem_ready = rdy;
    if (reset && imem.imem_req && rdy) begin
      pend      = 1'b1;
      pend_addr = imem.imem_addr;
      pend_cnt  = lat - 1;
    end
  endtask

  // Monitor / scoreboard
  logic   stall_prev = 1'b0;
  logic   clr_prev   = 1'b0;
  logic   model_valid = 1'b0;
  entry_t last_e;
  entry_t got_e;
  logic [PC_W-1:0] req_e;

  always @(negedge clk) begin
    while (dname_q.size() > 0) begin
      string       n;
      logic [63:0] g, x;
      n = dname_q.pop_front();
      g = dgot_q.pop_front();
      x = dexp_q.pop_front();
      checks++;
      if (g !== x) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, g, x);
      end
    end
    if (!reset) begin
      stall_prev  = 1'b0;
      clr_prev    = 1'b0;
      model_valid = 1'b0;
    end else begin
      if (imem.imem_req && imem.imem_ready) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected: addr %h expected no request", imem.imem_addr);
        end else begin
          req_e = exp_req.pop_front();
          if (imem.imem_addr !== req_e) begin
            errors++;
            $display("FAIL req_addr: got %h expected %h", imem.imem_addr, req_e);
          end
        end
      end
      if (clr_prev) begin
        checks++;
        if (valid_D !== 1'b0) begin
          errors++;
          $display("FAIL ifid_clear: valid_D %b expected 0", valid_D);
        end
        model_valid = 1'b0;
      end else if (stall_prev) begin
        checks++;
        if (valid_D !== model_valid ||
            (model_valid && (pc_D !== last_e.pc || instr_D !== last_e.instr))) begin
          errors++;
          $display("FAIL ifid_hold: got v=%b pc=%h i=%h expected v=%b pc=%h i=%h",
                   valid_D, pc_D, instr_D, model_valid, last_e.pc, last_e.instr);
        end
      end else if (valid_D !== 1'b0) begin
        checks++;
        if (exp_ifid.size() == 0) begin
          errors++;
          $display("FAIL ifid_unexpected: pc %h instr %h expected bubble", pc_D, instr_D);
        end else begin
          got_e = exp_ifid.pop_front();
          if (valid_D !== 1'b1 || pc_D !== got_e.pc || instr_D !== got_e.instr) begin
            errors++;
            $display("FAIL ifid_entry: got pc=%h i=%h expected pc=%h i=%h",
                     pc_D, instr_D, got_e.pc, got_e.instr);
          end
          last_e      = got_e;
          model_valid = 1'b1;
        end
      end else begin
        model_valid = 1'b0;
      end
      stall_prev = stall_D;
      clr_prev   = PCSrc_M | flush_D;
    end
  end

  initial begin
    reset           = 1'b0;
    PCSrc_M         = 1'b0;
    PCBranch_M      = '0;
    stall_D         = 1'b0;
    flush_D         = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_valid = 1'b0;
    imem.imem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    direct("rst_valid_D", 64'(valid_D), 64'h0);
    direct("rst_instr_D", 64'(instr_D), 64'h0);
    direct("rst_pc_D",    pc_D,         64'h0);
    direct("rst_addr",    imem.imem_addr, 64'h0);
    direct("rst_req",     64'(imem.imem_req), 64'h1);
    reset = 1'b1;

    // Sequential fetch 0, 4
    exp_req.push_back(64'h0);
    exp_req.push_back(64'h4);
    push_fetch(64'h0);
    push_fetch(64'h4);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Redirect while waiting on the response for 8
    exp_req.push_back(64'h8);
    exp_req.push_back(64'h100);
    push_fetch(64'h100);
    lat = 2;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    lat = 1;
    step(1'b1, 64'h100, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Redirect on the acceptance cycle to an unaligned target
    exp_req.push_back(64'h104);
    exp_req.push_back(64'h200);
    push_fetch(64'h200);
    step(1'b1, 64'h203, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Unaccepted redirect, then stall around the response for 0x10
    exp_req.push_back(64'hC);
    exp_req.push_back(64'h10);
    exp_req.push_back(64'h14);
    push_fetch(64'hC);
    push_fetch(64'h10);
    push_fetch(64'h14);
    step(1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Redirect while HOLD with stall, then a lone flush
    exp_req.push_back(64'h18);
    exp_req.push_back(64'h40);
    exp_req.push_back(64'h44);
    exp_req.push_back(64'h48);
    push_fetch(64'h40);
    push_fetch(64'h44);
    push_fetch(64'h48);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h40, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset while waiting on a slow response
    exp_req.push_back(64'h4C);
    lat = 3;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset           = 1'b0;
    imem.imem_ready = 1'b0;
    imem.imem_valid = 1'b0;
    pend            = 1'b0;
    #1;
    direct("async_valid_D", 64'(valid_D), 64'h0);
    direct("async_addr",    imem.imem_addr, 64'h0);
    direct("async_req",     64'(imem.imem_req), 64'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    lat   = 1;

    // Restart from the reset vector, then PC wrap at the top of memory
    exp_req.push_back(64'h0);
    exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req.push_back(64'h0);
    push_fetch(64'h0);
    push_fetch(64'hFFFF_FFFF_FFFF_FFFC);
    push_fetch(64'h0);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    direct("req_queue_empty",  64'(exp_req.size()),  64'h0);
    direct("ifid_queue_empty", 64'(exp_ifid.size()), 64'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch stage of the pipelined LEGv8 core. It directly consumes the memory stage's PCSrc_M redirect.
- Owns the PC register and issues requests to a variable-latency instruction memory.
- Drives the IF/ID pipeline register (instr_D, pc_D, valid_D) for decode.
- Discards wrong-path responses after a redirect and holds a fetched instruction while decode is stalled.

Parameters:
- PC_W, 64, PC and branch-target width.
- INSTR_W, 32, instruction width.
- RESET_VECTOR, 64'h0, PC value after reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- PCSrc_M  in  1  redirect request from the memory stage.
- PCBranch_M  in  PC_W  redirect target; bits [1:0] forced to 0 internally.
- stall_D  in  1  decode cannot accept a new instruction; IF/ID holds.
- flush_D  in  1  insert a bubble into IF/ID.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address (equals PC).
- imem_ready  in  1  memory accepts the request this cycle (req & ready = accepted).
- imem_valid  in  1  response data valid (one response per accepted request, in order, ≥1 cycle after acceptance).
- imem_rdata  in  INSTR_W  response instruction.
- instr_D  out  INSTR_W  IF/ID instruction.
- pc_D  out  PC_W  IF/ID PC of instr_D.
- valid_D  out  1  IF/ID entry valid.

Behaviour:
- Reset (reset=0, async): PC=RESET_VECTOR, state=FETCH, buffer empty, instr_D=0, pc_D=0, valid_D=0. imem_req=1 in the first cycle after reset release.
- At most one request is outstanding. imem_req=1 only in FETCH.
- Redirect (PCSrc_M=1) has priority over stall_D. On redirect:
  - PC <= {PCBranch_M[PC_W-1:2],2'b00}.
  - valid_D <= 0.
- States and transitions:
  - FETCH: imem_req=1, imem_addr=PC.
    - Accepted, no redirect -> WAIT.
    - Accepted with redirect the same cycle -> DRAIN (the old-PC response will be dropped).
    - Not accepted with redirect -> stay in FETCH with the new PC. The address may change while the request is unaccepted.
  - WAIT: waits for the response.
    - imem_valid & redirect -> drop the response, go to FETCH.
    - Redirect without imem_valid -> DRAIN.
    - imem_valid & !stall_D -> instr_D<=rdata, pc_D<=PC, valid_D<=1, PC<=PC+4, go to FETCH.
    - imem_valid & stall_D -> capture {rdata, PC} in the hold buffer, go to HOLD.
  - DRAIN: imem_valid -> discard the response, go to FETCH. A redirect in DRAIN updates PC and stays in DRAIN.
  - HOLD:
    - Redirect -> drop the buffer, go to FETCH.
    - !stall_D -> load the buffer into IF/ID (valid_D<=1), PC<=PC+4, go to FETCH.
    - Otherwise stay in HOLD.
- IF/ID update rules, in priority order:
  1. Redirect or flush_D -> valid_D<=0. instr_D/pc_D are don't-care but hold their old value.
  2. stall_D -> hold all three outputs.
  3. A new instruction is delivered -> load it.
  4. Otherwise -> valid_D<=0 (bubble).
- flush_D does not affect PC or the state machine. A response arriving with flush_D=1 and no redirect is still consumed and PC advances; the instruction is lost. Upstream asserts flush_D only together with a redirect or for a hazard bubble.
- PC+4 wraps modulo 2^PC_W.
- imem_valid outside WAIT/DRAIN is a protocol error; the block ignores it.
- Throughput: best case one instruction per 2 cycles (request cycle + response cycle). Fetch latency from redirect to the first valid_D on target is ≥2 cycles.
- Reset mid-operation aborts everything. Any in-flight memory response after reset release is the environment's responsibility: memory is reset with the core.

Decomposition:
- fetch_pkg holds:
  - typedef enum logic [1:0] {FETCH, WAIT, DRAIN, HOLD} fetch_state_t.
  - Constants PC_W, INSTR_W, INSTR_BYTES=4.
- One natural sub-module, ifid_reg: holds instr_D/pc_D/valid_D, with load, hold (stall), and clear (flush/redirect) controls, and an async active-low reset.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: reset low 3 cycles, memory ready=1, 1-cycle latency, returning addr-tagged data.
  - Required: imem_addr 0,4,8 on successive request cycles; valid_D pulses with pc_D=0,4,8 and matching instr_D.
- Redirect during WAIT:
  - Stimulus: request at PC=8 accepted, then PCSrc_M=1 with PCBranch_M=0x100 before the response.
  - Required: state DRAIN; the response for 8 is never shown on IF/ID (valid_D=0); next imem_addr=0x100; then pc_D=0x100 valid.
- Redirect same cycle as acceptance, unaligned target:
  - Stimulus: PCBranch_M=0x203 while imem_ready=1.
  - Required: old response discarded; next imem_addr=0x200.
- Stall while response arrives:
  - Stimulus: stall_D=1 for 3 cycles around imem_valid at PC=0x10.
  - Required: IF/ID holds its prior entry; no new imem_req during HOLD; on stall release pc_D=0x10, then imem_addr=0x14.
- Redirect while HOLD + flush:
  - Stimulus: in HOLD, assert PCSrc_M=1 to 0x40 with stall_D=1.
  - Required: buffer dropped; valid_D=0 next edge; imem_addr=0x40. Separately, flush_D alone gives valid_D=0 for one cycle.
- Async reset mid-WAIT:
  - Stimulus: reset=0 between clock edges.
  - Required: valid_D=0 and imem_addr=RESET_VECTOR immediately, without a clock edge.
